// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: FSM states, instruction fields and ALU codes.
// The decode helpers are used by the control FSM and its output logic.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_RTYPE   = 2'd0,
        CLS_LW      = 2'd1,
        CLS_SW      = 2'd2,
        CLS_ILLEGAL = 2'd3
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_AND = 6'b100100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    function automatic instr_class_e classify(input logic [31:0] instr);
        instr_class_e cls;
        cls = CLS_ILLEGAL;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FUNCT_ADD, FUNCT_SUB, FUNCT_OR, FUNCT_AND: cls = CLS_RTYPE;
                    default:                                    cls = CLS_ILLEGAL;
                endcase
            end
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            default: cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Loads and stores compute their address with an add.
    function automatic logic [1:0] alu_op_of(input logic [31:0] instr);
        logic [1:0] op;
        op = ALU_ADD;
        if (instr[31:26] == OP_RTYPE) begin
            case (instr[5:0])
                FUNCT_SUB: op = ALU_SUB;
                FUNCT_OR:  op = ALU_OR;
                FUNCT_AND: op = ALU_AND;
                default:   op = ALU_ADD;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/instr_buf.sv
// Instruction storage: DEPTH x 32, synchronous write, asynchronous read, no reset.
// Addresses at or beyond DEPTH are ignored on write and read as zero.
module instr_buf #(
    parameter int DEPTH = 15
) (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < 5'(DEPTH))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < 5'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: loads a program into instr_buf, then walks it
// through FETCH/DECODE/EXEC/MEM/WB, emitting datapath enables decoded from state and ir.
module cpu_seq_ctrl #(
    parameter int IMEM_DEPTH = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_instruction,
    input  logic        mem_write,
    input  logic        start,
    output logic [31:0] ir,
    output logic [3:0]  pc,
    output logic        rf_we,
    output logic        mem_we,
    output logic        mem_re,
    output logic        wb_sel,
    output logic [1:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  count,
    output logic [3:0]  load_cnt
);

    import cpu_pkg::*;

    localparam logic [3:0] DEPTH_L = 4'(IMEM_DEPTH);

    state_e       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic [3:0]   pc_q, pc_d;
    logic [3:0]   count_q, count_d;
    logic [3:0]   load_cnt_q, load_cnt_d;
    logic         err_q, err_d;
    logic         buf_we;
    logic [31:0]  buf_rdata;
    logic [3:0]   pc_inc;
    instr_class_e cls;

    instr_buf #(
        .DEPTH (IMEM_DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (load_cnt_q),
        .wdata (next_instruction),
        .raddr (pc_q),
        .rdata (buf_rdata)
    );

    assign pc_inc = pc_q + 4'd1;
    assign cls    = classify(ir_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            pc_q       <= '0;
            count_q    <= '0;
            load_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            load_cnt_q <= load_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        count_d    = count_q;
        load_cnt_d = load_cnt_q;
        err_d      = err_q;
        buf_we     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // start takes priority; a simultaneous load word is discarded
                if (start) begin
                    pc_d    = '0;
                    count_d = '0;
                    state_d = (load_cnt_q == 4'd0) ? ST_DONE : ST_FETCH;
                end else if (mem_write) begin
                    if (load_cnt_q == DEPTH_L) begin
                        err_d = 1'b1;
                    end else begin
                        buf_we     = rst;
                        load_cnt_d = load_cnt_q + 4'd1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ir_d    = buf_rdata;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls == CLS_ILLEGAL) begin
                    err_d   = 1'b1;
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = (cls == CLS_RTYPE) ? ST_WB : ST_MEM;
            end
            ST_MEM: begin
                if (cls == CLS_SW) begin
                    pc_d    = pc_inc;
                    count_d = count_q + 4'd1;
                    state_d = (pc_inc == load_cnt_q) ? ST_DONE : ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = pc_inc;
                count_d = count_q + 4'd1;
                state_d = (pc_inc == load_cnt_q) ? ST_DONE : ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rf_we  = 1'b0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        wb_sel = 1'b0;
        alu_op = ALU_ADD;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_FETCH, ST_DECODE: busy = 1'b1;
            ST_EXEC: begin
                busy   = 1'b1;
                alu_op = alu_op_of(ir_q);
            end
            ST_MEM: begin
                busy   = 1'b1;
                mem_we = (cls == CLS_SW);
                mem_re = (cls == CLS_LW);
            end
            ST_WB: begin
                busy   = 1'b1;
                rf_we  = 1'b1;
                wb_sel = (cls == CLS_LW);
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign ir       = ir_q;
    assign pc       = pc_q;
    assign count    = count_q;
    assign load_cnt = load_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: a trace-building program model checked every
// cycle, plus hand-computed checks for the directed scenarios.
module tb_cpu_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] next_instruction;
    logic        mem_write;
    logic        start;
    logic [31:0] ir;
    logic [3:0]  pc;
    logic        rf_we, mem_we, mem_re, wb_sel;
    logic [1:0]  alu_op;
    logic        busy, done, err;
    logic [3:0]  count;
    logic [3:0]  load_cnt;

    cpu_seq_ctrl #(.IMEM_DEPTH(15)) dut (
        .clk              (clk),
        .rst              (rst),
        .next_instruction (next_instruction),
        .mem_write        (mem_write),
        .start            (start),
        .ir               (ir),
        .pc               (pc),
        .rf_we            (rf_we),
        .mem_we           (mem_we),
        .mem_re           (mem_re),
        .wb_sel           (wb_sel),
        .alu_op           (alu_op),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .count            (count),
        .load_cnt         (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ir;
        logic [3:0]  pc;
        logic [3:0]  count;
        logic        busy;
        logic        done;
        logic        err;
        logic        rf_we;
        logic        mem_we;
        logic        mem_re;
        logic        wb_sel;
        logic [1:0]  alu_op;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        expv;
    exp_t        trace[$];
    logic        running     = 1'b0;
    logic        model_ready = 1'b0;
    logic [31:0] mdl_mem [16];
    logic [3:0]  mdl_load_cnt;
    logic [31:0] prog[$];

    function automatic logic [31:0] rIns(input logic [5:0] funct, input int rd);
        return {6'b000000, 5'd1, 5'd2, 5'(rd), 5'd0, funct};
    endfunction

    function automatic logic [31:0] lwIns(input int rt);
        return {6'b100011, 5'd1, 5'(rt), 16'h0004};
    endfunction

    function automatic logic [31:0] swIns(input int rt);
        return {6'b101011, 5'd1, 5'(rt), 16'h0008};
    endfunction

    // 0 = register op, 1 = load, 2 = store, 3 = illegal
    function automatic int modelClass(input logic [31:0] w);
        if (w[31:26] == 6'b100011) return 1;
        if (w[31:26] == 6'b101011) return 2;
        if (w[31:26] == 6'b000000 &&
            (w[5:0] == 6'b100000 || w[5:0] == 6'b100010 ||
             w[5:0] == 6'b100101 || w[5:0] == 6'b100100)) return 0;
        return 3;
    endfunction

    function automatic logic [1:0] modelAlu(input logic [31:0] w);
        if (w[31:26] != 6'b000000) return 2'b00;
        if (w[5:0] == 6'b100010) return 2'b01;
        if (w[5:0] == 6'b100101) return 2'b10;
        if (w[5:0] == 6'b100100) return 2'b11;
        return 2'b00;
    endfunction

    // Expand the loaded program into the per-cycle output trace of one run.
    task automatic buildTrace();
        exp_t        e;
        logic [3:0]  p;
        logic [3:0]  c;
        logic [31:0] cur_ir;
        logic [31:0] w;
        logic        cur_err;
        int          k;
        int          guard;
        p       = 4'd0;
        c       = 4'd0;
        cur_ir  = expv.ir;
        cur_err = expv.err;
        guard   = 0;
        trace.delete();
        while (mdl_load_cnt != 4'd0 && guard < 40) begin
            guard++;
            w = mdl_mem[p];
            k = modelClass(w);
            e = '0;
            e.busy = 1'b1; e.pc = p; e.count = c; e.err = cur_err; e.ir = cur_ir;
            trace.push_back(e);
            cur_ir = w;
            e.ir = w;
            trace.push_back(e);
            if (k == 3) begin
                cur_err = 1'b1;
                p = p + 4'd1;
                continue;
            end
            e.alu_op = modelAlu(w);
            trace.push_back(e);
            e.alu_op = 2'b00;
            if (k == 2) begin
                e.mem_we = 1'b1;
                trace.push_back(e);
            end else begin
                if (k == 1) begin
                    e.mem_re = 1'b1;
                    trace.push_back(e);
                    e.mem_re = 1'b0;
                end
                e.rf_we  = 1'b1;
                e.wb_sel = (k == 1);
                trace.push_back(e);
            end
            p = p + 4'd1;
            c = c + 4'd1;
            if (p == mdl_load_cnt) break;
        end
        e = '0;
        e.done = 1'b1; e.pc = p; e.count = c; e.ir = cur_ir; e.err = cur_err;
        trace.push_back(e);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            trace.delete();
            running      = 1'b0;
            expv         = '0;
            mdl_load_cnt = 4'd0;
        end else if (running) begin
            expv    = trace.pop_front();
            running = (trace.size() != 0);
        end else if (start) begin
            buildTrace();
            expv    = trace.pop_front();
            running = (trace.size() != 0);
        end else if (mem_write) begin
            if (mdl_load_cnt == 4'd15) begin
                expv.err = 1'b1;
            end else begin
                mdl_mem[mdl_load_cnt] = next_instruction;
                mdl_load_cnt = mdl_load_cnt + 4'd1;
            end
            expv.done = 1'b0;
        end
        model_ready = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("ir",       ir,               expv.ir);
            checkOutput("pc",       32'(pc),          32'(expv.pc));
            checkOutput("count",    32'(count),       32'(expv.count));
            checkOutput("load_cnt", 32'(load_cnt),    32'(mdl_load_cnt));
            checkOutput("busy",     32'(busy),        32'(expv.busy));
            checkOutput("done",     32'(done),        32'(expv.done));
            checkOutput("err",      32'(err),         32'(expv.err));
            checkOutput("rf_we",    32'(rf_we),       32'(expv.rf_we));
            checkOutput("mem_we",   32'(mem_we),      32'(expv.mem_we));
            checkOutput("mem_re",   32'(mem_re),      32'(expv.mem_re));
            checkOutput("wb_sel",   32'(wb_sel),      32'(expv.wb_sel));
            checkOutput("alu_op",   32'(alu_op),      32'(expv.alu_op));
        end
    end

    // Drive one cycle of inputs, returning 1 time unit after the edge that sampled them.
    task automatic applyStimulus(input logic r, input logic s, input logic w, input logic [31:0] instr);
        rst              = r;
        start            = s;
        mem_write        = w;
        next_instruction = instr;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        start     = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic loadProg();
        foreach (prog[i]) applyStimulus(1'b1, 1'b0, 1'b1, prog[i]);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 200) begin
            applyStimulus(1'b1, 1'b0, 1'b0, '0);
            cycles++;
        end
    endtask

    int cyc;

    initial begin
        rst = 1'b0; start = 1'b0; mem_write = 1'b0; next_instruction = '0;
        @(posedge clk);
        #1;
        resetDut();
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pc",   32'(pc),   32'd0);

        $display("[TB] empty program start, then start+write from DONE");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("empty_done",  32'(done),  32'd1);
        checkOutput("empty_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, rIns(6'b100000, 3));
        checkOutput("restart_done",     32'(done),     32'd1);
        checkOutput("restart_load_cnt", 32'(load_cnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, rIns(6'b100000, 3));
        checkOutput("write_from_done_done", 32'(done),     32'd0);
        checkOutput("write_from_done_cnt",  32'(load_cnt), 32'd1);

        $display("[TB] six-instruction program");
        resetDut();
        prog = '{rIns(6'b100000, 4), rIns(6'b100010, 5), rIns(6'b100101, 6),
                 swIns(7), lwIns(8), rIns(6'b100000, 9)};
        loadProg();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitDone(cyc);
        checkOutput("prog6_cycles", 32'(cyc),   32'd26);
        checkOutput("prog6_count",  32'(count), 32'd6);
        checkOutput("prog6_err",    32'(err),   32'd0);
        checkOutput("prog6_ir",     ir,         rIns(6'b100000, 9));

        $display("[TB] single load word");
        resetDut();
        prog = '{lwIns(3)};
        loadProg();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("lw_c4_mem_re", 32'(mem_re), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("lw_c5_rf_we",  32'(rf_we),  32'd1);
        checkOutput("lw_c5_wb_sel", 32'(wb_sel), 32'd1);
        waitDone(cyc);
        checkOutput("lw_count", 32'(count), 32'd1);

        $display("[TB] illegal opcode then ADD, with a write while busy");
        resetDut();
        prog = '{32'hFC00_0000, rIns(6'b100000, 2)};
        loadProg();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678);
        waitDone(cyc);
        checkOutput("illegal_done",     32'(done),     32'd1);
        checkOutput("illegal_err",      32'(err),      32'd1);
        checkOutput("illegal_count",    32'(count),    32'd1);
        checkOutput("illegal_pc",       32'(pc),       32'd2);
        checkOutput("busy_write_ignored", 32'(load_cnt), 32'd2);

        $display("[TB] reset during EXEC");
        resetDut();
        prog = '{rIns(6'b100000, 1), rIns(6'b100100, 2), lwIns(3)};
        loadProg();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("exec_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("abort_busy",  32'(busy),  32'd0);
        checkOutput("abort_ir",    ir,         32'd0);
        checkOutput("abort_enables", {28'd0, rf_we, mem_we, mem_re, wb_sel}, 32'd0);
        checkOutput("abort_load_cnt", 32'(load_cnt), 32'd0);
        loadProg();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitDone(cyc);
        checkOutput("rerun_count", 32'(count), 32'd3);
        checkOutput("rerun_ir",    ir,         lwIns(3));

        $display("[TB] overfill the buffer");
        resetDut();
        prog.delete();
        for (int i = 0; i < 15; i++) prog.push_back(rIns(6'b100000, i + 1));
        prog.push_back(rIns(6'b100010, 31));
        loadProg();
        checkOutput("full_load_cnt", 32'(load_cnt), 32'd15);
        checkOutput("full_err",      32'(err),      32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        waitDone(cyc);
        checkOutput("full_count", 32'(count), 32'd15);
        checkOutput("full_last_ir", ir, rIns(6'b100000, 15));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 15, meaning instruction buffer capacity in words.
REQ-002 SHALL have port clk  input  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port next_instruction  input  32  instruction word to load.
REQ-005 SHALL have port mem_write  input  1  load strobe; one word accepted per sampled-high cycle.
REQ-006 SHALL have port start  input  1  begin executing the loaded program from address 0.
REQ-007 SHALL have port ir  output  32  current instruction register.
REQ-008 SHALL have port pc  output  4  address of the current instruction.
REQ-009 SHALL have ports rf_we, mem_we, mem_re, wb_sel  output  1 each  datapath enables; wb_sel=1 selects memory data.
REQ-010 SHALL have port alu_op  output  2  00 ADD, 01 SUB, 10 OR, 11 AND.
REQ-011 SHALL have ports busy, done, err  output  1 each  running, program finished, sticky error.
REQ-012 SHALL have ports count and load_cnt  output  4 each  retired instructions and loaded words.

Function
REQ-013 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
REQ-014 In IDLE or DONE, a mem_write-high cycle SHALL write next_instruction at address load_cnt and increment load_cnt; a write from DONE SHALL move the FSM to IDLE.
REQ-015 When load_cnt equals IMEM_DEPTH, further writes SHALL be dropped and err set.
REQ-016 In IDLE or DONE, start SHALL clear pc and count and enter FETCH next cycle; start SHALL win over a simultaneous mem_write, which is dropped.
REQ-017 start with load_cnt=0 SHALL go directly to DONE.
REQ-018 In FETCH, ir SHALL load buffer[pc]; in DECODE, the opcode and funct SHALL be classified.
REQ-019 R-type (opcode 000000; funct 100000/100010/100101/100100) SHALL sequence FETCH-DECODE-EXEC-WB, with rf_we=1 and wb_sel=0 in WB.
REQ-020 LW (100011) SHALL sequence FETCH-DECODE-EXEC-MEM-WB, with alu_op=00 in EXEC, mem_re=1 in MEM, and rf_we=1 and wb_sel=1 in WB.
REQ-021 SW (101011) SHALL sequence FETCH-DECODE-EXEC-MEM, with alu_op=00 in EXEC and mem_we=1 in MEM.
REQ-022 An illegal opcode or funct in DECODE SHALL set err, increment pc, leave count unchanged, and return to FETCH.
REQ-023 On the final state of each legal instruction, pc and count SHALL increment.
REQ-024 After the final state, the FSM SHALL go to DONE if the new pc equals load_cnt, else to FETCH.
REQ-025 Datapath enables SHALL be decoded from the registered state and ir only, be valid for that state's cycle, and be 0 elsewhere.
REQ-026 busy SHALL be 1 in FETCH through WB; done SHALL be 1 in DONE only.
REQ-027 mem_write and start SHALL be ignored while busy.

Reset
REQ-028 While rst=0 at a clock edge, the FSM SHALL go to IDLE and pc, count, load_cnt, ir, err, busy, done and all enables SHALL become 0.
REQ-029 Reset mid-run SHALL abort with no further enables asserted; buffer contents SHALL NOT be cleared.

Structure
REQ-030 State encodings, opcode/funct constants and alu_op codes SHALL reside in shared package cpu_pkg.
REQ-031 The instruction storage SHALL be sub-module instr_buf: IMEM_DEPTH x 32, synchronous write, asynchronous read, no reset.

Verification
REQ-032 The bench SHALL load ADD, SUB, OR, SW, LW, ADD and pulse start -> DONE 26 cycles after start, count=6, err=0.
REQ-033 The bench SHALL load a single LW and start -> mem_re in cycle 4 and rf_we with wb_sel=1 in cycle 5 after start, count=1.
REQ-034 The bench SHALL write 16 words -> load_cnt=15, err=1, and word 16 absent.
REQ-035 The bench SHALL load opcode 111111 then ADD and start -> err=1, count=1, pc=2 in DONE.
REQ-036 The bench SHALL drive rst=0 during EXEC -> next cycle IDLE, all outputs 0, buffer reread correctly after reload of load_cnt via writes.
REQ-037 The bench SHALL pulse start with load_cnt=0 -> done=1 the next cycle and count=0; then assert start and mem_write together in DONE -> restart wins, load_cnt unchanged.
